multicycle_ctrl: RTL



---
 rtl/riscv_ctrl_pkg.sv | 60 ++++++
 rtl/imm_type_dec.sv | 25 ++
 rtl/multicycle_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StJal,
    StBeq
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ImmI = 2'b00,
    ImmS = 2'b01,
    ImmB = 2'b10,
    ImmJ = 2'b11
  } immsrc_e;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluFunct = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    ResAluOut = 2'b00,
    ResMdr    = 2'b01,
    ResAlu    = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SrcAPc    = 2'b00,
    SrcAOldPc = 2'b01,
    SrcARs1   = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SrcBRs2  = 2'b00,
    SrcBImm  = 2'b01,
    SrcBFour = 2'b10
  } alu_src_b_e;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OP_LOAD) || (opcode == OP_STORE);
  endfunction

endpackage

// File: rtl/imm_type_dec.sv
// Combinational opcode to immediate-format select; unknown opcodes fall back to I-type.
module imm_type_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [1:0] o_immsrc
);

  immsrc_e immsrc;

  always_comb begin
    immsrc = ImmI;
    case (i_opcode)
      OP_LOAD,
      OP_I:      immsrc = ImmI;
      OP_STORE:  immsrc = ImmS;
      OP_BRANCH: immsrc = ImmB;
      OP_JAL:    immsrc = ImmJ;
      default:   immsrc = ImmI;
    endcase
  end

  assign o_immsrc = immsrc;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback, and counts retired instructions.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [6:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_write,
  output logic             o_adr_src,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_reg_write,
  output logic [1:0]       o_result_src,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic [1:0]       o_immsrc,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic        retire;
  result_src_e result_src;
  alu_src_a_e  alu_src_a;
  alu_src_b_e  alu_src_b;
  alu_op_e     alu_op;

  imm_type_dec u_imm_type_dec (
    .i_opcode (i_opcode),
    .o_immsrc (o_immsrc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRs2;
    alu_op     = AluAdd;

    case (state_q)
      StFetch: begin
        // PC+4 goes straight from the ALU into PC while the IR captures the word.
        mem_req    = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAlu;
        ir_write   = i_mem_ready;
        pc_write   = i_mem_ready;
        if (i_mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Speculatively form oldPC+imm so branch/jump targets sit in ALUOut.
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        if (is_mem_op(i_opcode)) begin
          state_d = StMemAdr;
        end else begin
          case (i_opcode)
            OP_R:      state_d = StExecR;
            OP_I:      state_d = StExecI;
            OP_JAL:    state_d = StJal;
            OP_BRANCH: state_d = StBeq;
            default: begin
              state_d = StFetch;
              illegal = 1'b1;
            end
          endcase
        end
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        state_d   = (i_opcode == OP_LOAD) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (i_mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = ResMdr;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (i_mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExecR: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBRs2;
        alu_op    = AluFunct;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        alu_op    = AluFunct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StJal: begin
        // Target from ALUOut into PC while the ALU forms the link value oldPC+4.
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_write  = 1'b1;
        state_d   = StAluWb;
      end
      StBeq: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBRs2;
        alu_op    = AluSub;
        pc_write  = i_zero;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  assign retired_d = retire ? (retired_q + CntOne) : retired_q;

  // Strobes are forced low throughout reset so an abandoned access ends immediately.
  assign o_mem_req    = mem_req   & i_rst_n;
  assign o_mem_write  = mem_write & i_rst_n;
  assign o_ir_write   = ir_write  & i_rst_n;
  assign o_pc_write   = pc_write  & i_rst_n;
  assign o_reg_write  = reg_write & i_rst_n;
  assign o_illegal    = illegal   & i_rst_n;
  assign o_adr_src    = adr_src;
  assign o_result_src = result_src;
  assign o_alu_src_a  = alu_src_a;
  assign o_alu_src_b  = alu_src_b;
  assign o_alu_op     = alu_op;
  assign o_retired    = retired_q;

endmodule
